pc_sequencer: RTL and testbench

- Fetch/next-PC controller for the single-cycle core.
- Owns the architectural PC and runs the instruction-memory request/ack handshake.
- Consumes the jump unit's target (JAL/JALR select and computed target) and the branch unit's target, and selects the next PC.
- Traps on misaligned control-flow targets.
- Sits between the imem port and the execute stage.

---
 rtl/pc_sequencer.sv | 97 +++++++++
 tb/tb_pc_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/next-PC controller owning the PC and the imem request/ack handshake
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned ACK_TIMEOUT  = 15
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_imem_req,
  output logic [31:0] io_imem_addr,
  input  logic        io_imem_ack,
  input  logic        io_stall,
  input  logic [1:0]  io_JmpCtrl,
  input  logic [31:0] io_J_target,
  input  logic        io_br_taken,
  input  logic [31:0] io_br_target,
  output logic [31:0] io_pc,
  output logic [31:0] io_link,
  output logic        io_instr_valid,
  output logic        io_trap,
  output logic [1:0]  io_trap_cause,
  output logic [1:0]  io_state
);
  typedef enum logic [1:0] {BOOT = 2'b00, FETCH = 2'b01, EXEC = 2'b10, TRAP = 2'b11} state_t;
  localparam logic [3:0] LIMIT = 4'(ACK_TIMEOUT - 1);
  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] pc;
  logic [31:0] target;
  assign io_pc        = pc;
  assign io_imem_addr = pc;
  assign io_link      = pc + 32'd4;
  assign io_state     = state;
  // next-PC candidate: jump beats branch beats sequential; JALR clears bit0
  always_comb
    target = io_JmpCtrl == 2'b00 ? io_J_target
           : io_JmpCtrl == 2'b01 ? {io_J_target[31:1], 1'b0}
           : io_br_taken         ? io_br_target
           : io_link;
  // sequencer FSM; outputs are registered alongside each state transition
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= BOOT;
      pc             <= RESET_VECTOR;
      cnt            <= 4'd0;
      io_imem_req    <= 1'b0;
      io_instr_valid <= 1'b0;
      io_trap        <= 1'b0;
      io_trap_cause  <= 2'b00;
    end else begin
      case (state)
        BOOT: begin
          state       <= FETCH;
          io_imem_req <= 1'b1;
        end
        FETCH: begin
          if (io_imem_ack) begin
            state          <= EXEC;
            cnt            <= 4'd0;
            io_imem_req    <= 1'b0;
            io_instr_valid <= 1'b1;
          end else if (cnt == LIMIT) begin
            state         <= TRAP;
            cnt           <= 4'd0;
            io_imem_req   <= 1'b0;
            io_trap       <= 1'b1;
            io_trap_cause <= 2'b10;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        EXEC: begin
          if (!io_stall) begin
            io_instr_valid <= 1'b0;
            if (target[1:0] != 2'b00) begin
              state         <= TRAP;
              io_trap       <= 1'b1;
              io_trap_cause <= 2'b01;
            end else begin
              state       <= FETCH;
              pc          <= target;
              io_imem_req <= 1'b1;
            end
          end
        end
        TRAP: begin
          state         <= FETCH;
          pc            <= TRAP_VECTOR;
          io_trap       <= 1'b0;
          io_trap_cause <= 2'b00;
          io_imem_req   <= 1'b1;
        end
        default: state <= BOOT;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed stimulus with a queue scoreboard checked by an independent monitor
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack, stall, br_taken, instr_valid, trap;
  logic [31:0] imem_addr, j_target, br_target, pc, link;
  logic [1:0]  jmp_ctrl, trap_cause, state;
  int total = 0;
  int bad = 0;
  typedef struct {bit trap; logic [1:0] cause; logic [31:0] pc;} ev_t;
  ev_t q[$];
  bit prev_valid = 1'b0;

  pc_sequencer dut (
    .clock(clk), .reset(rst_n),
    .io_imem_req(imem_req), .io_imem_addr(imem_addr), .io_imem_ack(imem_ack),
    .io_stall(stall), .io_JmpCtrl(jmp_ctrl), .io_J_target(j_target),
    .io_br_taken(br_taken), .io_br_target(br_target),
    .io_pc(pc), .io_link(link), .io_instr_valid(instr_valid),
    .io_trap(trap), .io_trap_cause(trap_cause), .io_state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic ev_t ex(input logic [31:0] p);
    ex = '{trap: 1'b0, cause: 2'b00, pc: p};
  endfunction

  function automatic ev_t tr(input logic [31:0] p, input logic [1:0] c);
    tr = '{trap: 1'b1, cause: c, pc: p};
  endfunction

  // monitor: pops one expected event on each EXEC entry and each trap cycle
  always @(negedge clk) begin
    if (!rst_n) prev_valid = 1'b0;
    else begin
      if (imem_req) chk("fetch_addr", imem_addr, pc);
      if (!trap) chk("cause_idle", {30'd0, trap_cause}, 32'd0);
      if ((instr_valid && !prev_valid) || trap) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event pc=%h trap=%b", pc, trap);
        end else begin
          ev_t e;
          e = q.pop_front();
          chk("ev_kind", {31'd0, trap}, {31'd0, e.trap});
          chk("ev_pc", pc, e.pc);
          chk("ev_link", link, e.pc + 32'd4);
          chk("ev_cause", {30'd0, trap_cause}, {30'd0, e.cause});
        end
      end
      prev_valid = instr_valid;
    end
  end

  task automatic defaults();
    stall = 1'b0; jmp_ctrl = 2'b10; j_target = '0; br_taken = 1'b0; br_target = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1 defaults();
  endtask

  task automatic wait_exec();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (instr_valid && state == 2'b10) return;
    end
    total++;
    bad++;
    $display("FAIL exec_timeout pc=%h state=%h", pc, state);
  endtask

  initial begin
    int n;
    defaults();
    imem_ack = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_trap", {31'd0, trap}, 32'd0);
    q.push_back(ex(32'h0)); q.push_back(ex(32'h4)); q.push_back(ex(32'h8));
    q.push_back(ex(32'h10)); q.push_back(ex(32'h40)); q.push_back(tr(32'h40, 2'b01));
    q.push_back(ex(32'h100)); q.push_back(ex(32'hFFFF_FFFC)); q.push_back(ex(32'h0));
    q.push_back(ex(32'h80)); q.push_back(tr(32'h84, 2'b10)); q.push_back(ex(32'h100));
    q.push_back(ex(32'h0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("boot_to_fetch", {30'd0, state}, 32'd1);
    chk("boot_req", {31'd0, imem_req}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("cadence_valid", {31'd0, instr_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    jmp_ctrl = 2'b00; j_target = 32'h10;
    step(); wait_exec();
    jmp_ctrl = 2'b00; j_target = 32'h40; br_taken = 1'b1; br_target = 32'h80;
    step(); wait_exec();
    jmp_ctrl = 2'b01; j_target = 32'h0000_0203;
    step(); wait_exec();
    jmp_ctrl = 2'b00; j_target = 32'hFFFF_FFFC;
    step(); wait_exec();
    step(); wait_exec();
    jmp_ctrl = 2'b00; j_target = 32'h80; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_pc", pc, 32'h0);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    stall = 1'b0;
    step(); wait_exec();
    imem_ack = 1'b0;
    step();
    n = 0;
    for (int i = 0; i < 40 && !trap; i++) begin
      @(negedge clk);
      if (imem_req) n++;
    end
    chk("timeout_fetch_cycles", n, 15);
    imem_ack = 1'b1;
    wait_exec();
    imem_ack = 1'b0;
    step();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, imem_req}, 32'd0);
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_state", {30'd0, state}, 32'd0);
    imem_ack = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ack_ignored", {30'd0, state}, 32'd0);
    rst_n = 1'b1;
    wait_exec();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
